// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetches instruction words over a req/ack memory port and hands them to the instruction register
// Ports: clock/reset (async, active-high); enable keeps fetching;
//   mem_req/mem_addr/mem_rdata/mem_ack form the memory read handshake;
//   IR_in/IRWrite/ir_pc carry the held word to the control unit, which accepts it with ir_ready;
//   pc is the next fetch address; redirect/redirect_pc retarget fetching;
//   fetch_count counts delivered words.
module instruction_fetch_unit #(
    parameter int ADDR_W = 16,
    parameter int INSTR_W = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               mem_ack,
    output logic [INSTR_W-1:0] IR_in,
    output logic               IRWrite,
    input  logic               ir_ready,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic [ADDR_W-1:0]  pc,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [15:0]        fetch_count
);
    typedef enum logic [1:0] {IDLE, REQ, DELIVER} state_t;
    state_t state;
    logic flush;
    logic transfer;
    logic [ADDR_W-1:0] next_pc;
    assign transfer = IRWrite & ir_ready;
    assign next_pc = redirect ? redirect_pc : pc;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            mem_req     <= 1'b0;
            mem_addr    <= RESET_PC;
            IR_in       <= '0;
            IRWrite     <= 1'b0;
            ir_pc       <= '0;
            fetch_count <= '0;
            flush       <= 1'b0;
        end else begin
            if (redirect) pc <= redirect_pc;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state    <= REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= next_pc;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        // a read that was redirected away is discarded and re-issued at the new pc
                        if (flush || redirect) begin
                            flush    <= 1'b0;
                            state    <= enable ? REQ : IDLE;
                            mem_req  <= enable;
                            mem_addr <= next_pc;
                        end else begin
                            IR_in   <= mem_rdata;
                            ir_pc   <= pc;
                            pc      <= pc + ADDR_W'(1);
                            state   <= DELIVER;
                            mem_req <= 1'b0;
                            IRWrite <= 1'b1;
                        end
                    end else if (redirect) begin
                        flush <= 1'b1;
                    end
                end
                DELIVER: begin
                    if (transfer) fetch_count <= fetch_count + 16'd1;
                    // an un-accepted word is dropped on redirect; an accepted one still counts
                    if (transfer || redirect) begin
                        IRWrite  <= 1'b0;
                        state    <= enable ? REQ : IDLE;
                        mem_req  <= enable;
                        mem_addr <= next_pc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: table-driven cycle vectors plus an asynchronous reset sequence
module tb_instruction_fetch_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [15:0] IR_in;
    logic        IRWrite;
    logic        ir_ready = 1'b0;
    logic [15:0] ir_pc;
    logic [15:0] pc;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic [15:0] fetch_count;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        en, ack, rdy, rd;
        logic [15:0] rpc, rdata;
        logic        req;
        logic [15:0] addr;
        logic        irw;
        logic [15:0] ir, irpc, cnt, pcv;
    } vec_t;
    vec_t v[$];

    instruction_fetch_unit dut (
        .clock(clock), .reset(reset), .enable(enable),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .IR_in(IR_in), .IRWrite(IRWrite), .ir_ready(ir_ready), .ir_pc(ir_pc), .pc(pc),
        .redirect(redirect), .redirect_pc(redirect_pc), .fetch_count(fetch_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%h expected=%h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic req, input logic [15:0] addr, input logic irw,
                           input logic [15:0] ir, input logic [15:0] irpc, input logic [15:0] cnt,
                           input logic [15:0] pcv);
        chk("mem_req", idx, 16'(mem_req), 16'(req));
        chk("mem_addr", idx, mem_addr, addr);
        chk("IRWrite", idx, 16'(IRWrite), 16'(irw));
        chk("IR_in", idx, IR_in, ir);
        chk("ir_pc", idx, ir_pc, irpc);
        chk("fetch_count", idx, fetch_count, cnt);
        chk("pc", idx, pc, pcv);
    endtask

    initial begin
        //            en ack rdy rd rpc      rdata     req addr     irw ir       irpc     cnt pc
        v.push_back('{1, 0, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000});
        v.push_back('{1, 1, 1, 0, 16'h0000, 16'h1234, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000});
        v.push_back('{1, 0, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 16'h1234, 16'h0000, 0, 16'h0001});
        v.push_back('{1, 1, 1, 0, 16'h0000, 16'hA5C3, 1, 16'h0001, 0, 16'h1234, 16'h0000, 1, 16'h0001});
        v.push_back('{0, 0, 1, 0, 16'h0000, 16'h0000, 0, 16'h0001, 1, 16'hA5C3, 16'h0001, 1, 16'h0002});
        v.push_back('{0, 0, 1, 0, 16'h0000, 16'h0000, 0, 16'h0002, 0, 16'hA5C3, 16'h0001, 2, 16'h0002});
        v.push_back('{1, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0002, 0, 16'hA5C3, 16'h0001, 2, 16'h0002});
        v.push_back('{1, 1, 0, 0, 16'h0000, 16'h5A5A, 1, 16'h0002, 0, 16'hA5C3, 16'h0001, 2, 16'h0002});
        v.push_back('{1, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0002, 1, 16'h5A5A, 16'h0002, 2, 16'h0003});
        v.push_back('{1, 1, 0, 0, 16'h0000, 16'hFFFF, 0, 16'h0002, 1, 16'h5A5A, 16'h0002, 2, 16'h0003});
        v.push_back('{1, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0002, 1, 16'h5A5A, 16'h0002, 2, 16'h0003});
        v.push_back('{1, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0002, 1, 16'h5A5A, 16'h0002, 2, 16'h0003});
        v.push_back('{1, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0002, 1, 16'h5A5A, 16'h0002, 2, 16'h0003});
        v.push_back('{1, 0, 1, 0, 16'h0000, 16'h0000, 0, 16'h0002, 1, 16'h5A5A, 16'h0002, 2, 16'h0003});
        v.push_back('{1, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0003, 0, 16'h5A5A, 16'h0002, 3, 16'h0003});
        v.push_back('{1, 0, 0, 1, 16'h0040, 16'h0000, 1, 16'h0003, 0, 16'h5A5A, 16'h0002, 3, 16'h0003});
        v.push_back('{1, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0003, 0, 16'h5A5A, 16'h0002, 3, 16'h0040});
        v.push_back('{1, 1, 0, 0, 16'h0000, 16'hDEAD, 1, 16'h0003, 0, 16'h5A5A, 16'h0002, 3, 16'h0040});
        v.push_back('{1, 1, 0, 0, 16'h0000, 16'h0F0F, 1, 16'h0040, 0, 16'h5A5A, 16'h0002, 3, 16'h0040});
        v.push_back('{1, 0, 1, 1, 16'h0100, 16'h0000, 0, 16'h0040, 1, 16'h0F0F, 16'h0040, 3, 16'h0041});
        v.push_back('{1, 1, 0, 0, 16'h0000, 16'h7777, 1, 16'h0100, 0, 16'h0F0F, 16'h0040, 4, 16'h0100});
        v.push_back('{1, 0, 0, 1, 16'hFFFF, 16'h0000, 0, 16'h0100, 1, 16'h7777, 16'h0100, 4, 16'h0101});
        v.push_back('{1, 1, 1, 0, 16'h0000, 16'hBEEF, 1, 16'hFFFF, 0, 16'h7777, 16'h0100, 4, 16'hFFFF});
        v.push_back('{1, 0, 1, 0, 16'h0000, 16'h0000, 0, 16'hFFFF, 1, 16'hBEEF, 16'hFFFF, 4, 16'h0000});
        v.push_back('{1, 1, 0, 1, 16'h0200, 16'h1111, 1, 16'h0000, 0, 16'hBEEF, 16'hFFFF, 5, 16'h0000});
        v.push_back('{0, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0200, 0, 16'hBEEF, 16'hFFFF, 5, 16'h0200});
        v.push_back('{0, 1, 0, 0, 16'h0000, 16'h2222, 1, 16'h0200, 0, 16'hBEEF, 16'hFFFF, 5, 16'h0200});
        v.push_back('{0, 0, 1, 0, 16'h0000, 16'h0000, 0, 16'h0200, 1, 16'h2222, 16'h0200, 5, 16'h0201});
        v.push_back('{0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0201, 0, 16'h2222, 16'h0200, 6, 16'h0201});
        v.push_back('{0, 0, 0, 1, 16'h0300, 16'h0000, 0, 16'h0201, 0, 16'h2222, 16'h0200, 6, 16'h0201});
        v.push_back('{0, 1, 1, 0, 16'h0000, 16'h0000, 0, 16'h0201, 0, 16'h2222, 16'h0200, 6, 16'h0300});
        v.push_back('{1, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0201, 0, 16'h2222, 16'h0200, 6, 16'h0300});
        v.push_back('{1, 1, 0, 0, 16'h0000, 16'h3333, 1, 16'h0300, 0, 16'h2222, 16'h0200, 6, 16'h0300});
        v.push_back('{1, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0300, 1, 16'h3333, 16'h0300, 6, 16'h0301});

        @(negedge clock);
        chk_all(-1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        reset = 1'b0;
        foreach (v[i]) begin
            @(negedge clock);
            enable      = v[i].en;
            mem_ack     = v[i].ack;
            ir_ready    = v[i].rdy;
            redirect    = v[i].rd;
            redirect_pc = v[i].rpc;
            mem_rdata   = v[i].rdata;
            #1;
            chk_all(i, v[i].req, v[i].addr, v[i].irw, v[i].ir, v[i].irpc, v[i].cnt, v[i].pcv);
        end

        // asynchronous reset while a word is being held on IRWrite
        chk("pre_reset_IRWrite", 100, 16'(IRWrite), 16'h0001);
        #2 reset = 1'b1;
        #1 chk_all(101, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        enable = 1'b0;
        mem_ack = 1'b0;
        ir_ready = 1'b0;
        redirect = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        #1 chk_all(102, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
